seg7_sum_display: RTL and testbench
===================================

# seg7_sum_display

Downstream consumer of the 4-bit ripple adder's 5-bit sum (0..31). Captures a sum on a load strobe and converts it to two BCD digits with a sequential shift-add-3 converter. It then drives a two-digit multiplexed common-anode 7-segment display by time-slicing the digit enables. It is the only sequential stage between the adder and the board pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0; 0 means a lit segment is driven 1.
- `clk` in 1: the single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture strobe; sampled only when `busy` = 0.
- `sum` in 5: adder result, unsigned 0..31.
- `busy` out 1: conversion in progress.
- `valid` out 1: display holds a converted value.
- `seg` out 7: {g,f,e,d,c,b,a}; polarity set by `SEG_ACTIVE_LOW`.
- `an` out 2: digit enables, active low; `an[0]` is units, `an[1]` is tens.

## Operation
- FSM states: IDLE, CONV.
  - IDLE with `load` = 1: capture `sum` into a 5-bit shift register, clear the 8-bit BCD register, clear the iteration counter, go to CONV.
  - CONV: one iteration per cycle, for exactly 5 iterations.
    - Each iteration: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
    - After the 5th iteration: copy the BCD into the display registers `tens`/`units`, set `valid` = 1, return to IDLE.
- `load` while `busy` = 1 is ignored, not queued.
- Result ranges: `tens` 0..3, `units` 0..9. Examples: 31 → 3/1, 10 → 1/0, 0 → 0/0.
- Scan:
  - Free-running counter 0..`REFRESH_DIV`-1. On wrap, toggle `sel`.
  - `sel` = 0: units slot, `an` = 2'b10. `sel` = 1: tens slot, `an` = 2'b11 and segments off when blanked per Configuration, otherwise `an` = 2'b01.
  - The scan runs regardless of FSM state. The display registers change only at conversion end, so there is no partial-value flicker.
- While `valid` = 0: `an` = 2'b11 and all segments off.
- Decoder: standard digit patterns, active-high form {g..a}.
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Inverted when `SEG_ACTIVE_LOW` = 1. Nibble values 10..15 cannot occur; decode them as all segments off.
- Reset values, asynchronous on `rst_n` low and taking effect at any time including mid-conversion:
  - `busy` = 0, `valid` = 0, `an` = 2'b11, `seg` = all off.
  - FSM in IDLE; scan counter and `sel` = 0; `tens` = `units` = 0.
  - An aborted conversion is discarded.

## Timing
- `load` sampled at edge E0 → `busy` = 1 after E0.
- Conversion iterations occur at E1..E5. At E5 the display registers update, `valid` = 1, and `busy` = 0.
- `seg`/`an` are registered and reflect the new value after E6.
- The earliest next accepted `load` is sampled at E6, since `busy` is low during the cycle after E5.
- A `load` asserted during the cycle ending at E5 is ignored, because `busy` is still 1.
- Digit slot length is exactly `REFRESH_DIV` cycles. `an` and `seg` change on the same edge, with no overlap cycle.
- Full two-digit refresh period: 2 × `REFRESH_DIV` cycles.

## Configuration
- `SEG7_BLANK_LEADING_ZERO_EN`
  - Defined: when `tens` = 0, the tens slot drives `an` = 2'b11 and segments off; the slot timing is unchanged.
  - Undefined: the tens digit always displays, including a leading 0.

## Test plan
All scenarios use `REFRESH_DIV` = 4 and `SEG_ACTIVE_LOW` = 1.
- Reset, then idle for 20 cycles → `an` = 2'b11, `seg` = 7'b1111111, `busy` = 0, `valid` = 0.
- `load` = 1 with `sum` = 23 → `busy` high for 5 cycles. Then units slot shows `an` = 2'b10, `seg` = 7'b0110000 (3); tens slot shows `an` = 2'b01, `seg` = 7'b0100100 (2); slots alternate every 4 cycles.
- `sum` = 31, then `sum` = 30 pulsed 2 cycles after the first load → second load ignored; display shows 3/1.
- `sum` = 7:
  - Macro defined → tens slot `an` = 2'b11, units slot `seg` = 7'b1111000.
  - Macro undefined → tens slot `seg` = 7'b1000000.
- `rst_n` low during the 3rd conversion cycle of `sum` = 19 → immediate reset values; after release `valid` = 0 until a new load.
- Sweep `sum` 0..31 with back-to-back loads at minimum spacing (6 cycles) → each decoded tens/units pair equals `sum`/10 and `sum`%10.

Source files
------------

// File: rtl/seg7_sum_display.sv
// Captures a 5-bit adder sum, converts it to BCD with a 5-step shift-add-3 loop and
// drives a two-digit multiplexed 7-segment display. Optional macro: SEG7_BLANK_LEADING_ZERO_EN.
module seg7_sum_display #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] sum,
    output logic       busy,
    output logic       valid,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned    CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  SCAN_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start;
    logic          w_done;

    logic [4:0]    r_bin;
    logic [7:0]    r_bcd;
    logic [2:0]    r_iter;
    logic [3:0]    r_tens;
    logic [3:0]    r_units;
    logic          r_valid;

    logic [CW-1:0] r_scan;
    logic          r_sel;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic [3:0]    w_adj_lo;
    logic [3:0]    w_adj_hi;
    logic [7:0]    w_bcd_nxt;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [1:0]    w_an_nxt;

    // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles decode to blank.
    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_iter == 3'd4) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One shift-add-3 step: correct each nibble, then shift {bcd, bin} left by one.
    always_comb begin
        w_adj_lo  = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_adj_hi  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_bcd_nxt = {w_adj_hi[2:0], w_adj_lo, r_bin[4]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_tens  <= '0;
            r_units <= '0;
            r_valid <= 1'b0;
        end else if (w_start) begin
            r_bin  <= sum;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == ST_CONV) begin
            r_bin  <= {r_bin[3:0], 1'b0};
            r_bcd  <= w_bcd_nxt;
            r_iter <= r_iter + 3'd1;
            if (w_done) begin
                r_tens  <= w_bcd_nxt[7:4];
                r_units <= w_bcd_nxt[3:0];
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_sel  <= 1'b0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_sel  <= ~r_sel;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    assign w_blank = (r_tens == 4'd0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_an_nxt  = 2'b11;
        if (r_valid) begin
            if (!r_sel) begin
                w_an_nxt  = 2'b10;
                w_seg_nxt = decode(r_units);
            end else if (!w_blank) begin
                w_an_nxt  = 2'b01;
                w_seg_nxt = decode(r_tens);
            end
        end
    end

    // Registered pins so an and seg switch together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_an  <= 2'b11;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign busy  = (r_state == ST_CONV);
    assign valid = r_valid;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_seg7_sum_display.sv
// Scoreboard bench for seg7_sum_display with REFRESH_DIV=4, active-low segments.
module tb_seg7_sum_display;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [4:0] sum;
    logic       busy;
    logic       valid;
    logic [6:0] seg;
    logic [1:0] an;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    seg7_sum_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .sum  (sum),
        .busy (busy),
        .valid(valid),
        .seg  (seg),
        .an   (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Active-low expected segment pattern for a decimal digit.
    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b0111111;
            4'd1: p = 7'b0000110;
            4'd2: p = 7'b1011011;
            4'd3: p = 7'b1001111;
            4'd4: p = 7'b1100110;
            4'd5: p = 7'b1101101;
            4'd6: p = 7'b1111101;
            4'd7: p = 7'b0000111;
            4'd8: p = 7'b1111111;
            4'd9: p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return ~p;
    endfunction

    function automatic bit tens_blank(input logic [3:0] t);
        return BLANK_EN && (t == 4'd0);
    endfunction

    logic [7:0] sb_q[$];
    logic [7:0] cur, nxt;
    bit         act = 1'b0;
    bit         pend = 1'b0;
    logic       prev_busy = 1'b0;
    int         seen_u, seen_t;

    task automatic finalize();
        check_eq("units_shown", 32'(seen_u > 0), 32'd1);
        if (tens_blank(cur[7:4])) check_eq("tens_hidden", 32'(seen_t), 32'd0);
        else                      check_eq("tens_shown", 32'(seen_t > 0), 32'd1);
    endtask

    // Display monitor: result popped when busy drops, shown from the following sample on.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_valid", 32'(valid), 32'd0);
            check_eq("rst_an", 32'(an), 32'h3);
            check_eq("rst_seg", 32'(seg), 32'h7F);
            act = 1'b0;
            pend = 1'b0;
            prev_busy = 1'b0;
            sb_q.delete();
        end else begin
            if (pend) begin
                if (act) finalize();
                act = 1'b1;
                pend = 1'b0;
                cur = nxt;
                seen_u = 0;
                seen_t = 0;
            end
            if (act) begin
                case (an)
                    2'b10: begin
                        check_eq("units_seg", 32'(seg), 32'(exp_seg(cur[3:0])));
                        seen_u++;
                    end
                    2'b01: begin
                        check_eq("tens_an", 32'(an), tens_blank(cur[7:4]) ? 32'h3 : 32'h1);
                        check_eq("tens_seg", 32'(seg), 32'(exp_seg(cur[7:4])));
                        seen_t++;
                    end
                    default: begin
                        check_eq("dark_an", 32'(an), 32'h3);
                        check_eq("dark_seg", 32'(seg), 32'h7F);
                    end
                endcase
            end else begin
                check_eq("blank_an", 32'(an), 32'h3);
                check_eq("blank_seg", 32'(seg), 32'h7F);
            end
            if (prev_busy && !busy) begin
                check_eq("valid_after_conv", 32'(valid), 32'd1);
                check_eq("result_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    nxt = sb_q.pop_front();
                    pend = 1'b1;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic pulse_load(input logic [4:0] s, input bit accepted);
        @(negedge clk);
        load = 1'b1;
        sum  = s;
        if (accepted) sb_q.push_back({4'(s / 10), 4'(s % 10)});
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        logic [1:0] prev_an;

        rst_n = 1'b0;
        load  = 1'b0;
        sum   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (20) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(valid), 32'd0);
        check_eq("idle_an", 32'(an), 32'h3);
        check_eq("idle_seg", 32'(seg), 32'h7F);

        // 23: busy width and slot lengths
        pulse_load(5'd23, 1'b1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_cycles", 32'(n), 32'd5);
        repeat (2) @(negedge clk);
        prev_an = an;
        n = 0;
        while (an == prev_an && n < 10) begin
            n++;
            @(negedge clk);
        end
        check_eq("slot_change_seen", 32'(an != prev_an), 32'd1);
        for (int r = 0; r < 3; r++) begin
            len = 1;
            prev_an = an;
            @(negedge clk);
            while (an == prev_an && len < 10) begin
                len++;
                @(negedge clk);
            end
            check_eq("slot_len", 32'(len), 32'd4);
        end

        // 31 then ignored 30 two cycles later
        pulse_load(5'd31, 1'b1);
        pulse_load(5'd30, 1'b0);
        repeat (16) @(negedge clk);

        pulse_load(5'd7, 1'b1);
        repeat (16) @(negedge clk);

        // reset during third conversion cycle of 19
        pulse_load(5'd19, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_an", 32'(an), 32'h3);
        check_eq("abort_seg", 32'(seg), 32'h7F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post_abort_valid", 32'(valid), 32'd0);

        // sweep at minimum load spacing
        for (int s = 0; s < 32; s++) begin
            pulse_load(5'(s), 1'b1);
            repeat (4) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        @(posedge clk);
        if (act) finalize();
        check_eq("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
